// File: rtl/c1_accum_w.sv
// Sequential ones'-complement accumulator: sums a valid/ready word stream with
// end-around carry and holds the packet result until the consumer takes it.
module c1_accum_w #(
  parameter int unsigned W       = 16,
  parameter int unsigned CNT_W   = 8,
  parameter bit          OUT_INV = 1'b0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_negz
);

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_e;

  localparam logic [W-1:0]     ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               in_ready_q, out_valid_q, out_ovf_q, out_negz_q;
  logic [W-1:0]       out_sum_q;
  logic [CNT_W-1:0]   out_cnt_q;

  logic [W-1:0]       op;
  logic [W:0]         sum_ext;
  logic [W-1:0]       acc_add;
  logic               ovf_add;

  // One C1 add step; the carry fold-back can never carry out again.
  always_comb begin
    op      = in_sub ? ~in_data : in_data;
    sum_ext = {1'b0, acc_q} + {1'b0, op};
    acc_add = sum_ext[W-1:0] + W'(sum_ext[W]);
    ovf_add = (acc_q[W-1] == op[W-1]) && (acc_add[W-1] != op[W-1]);
  end

  // Next state; output registers load the view of the next acc/cnt/ovf.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_d = acc_add;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d = ovf_q | ovf_add;
          if (in_last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= OUT_INV ? ALL_ONES : '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_negz_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ST_ACC);
      out_valid_q <= (state_d == ST_HOLD);
      out_sum_q   <= OUT_INV ? ~acc_d : acc_d;
      out_cnt_q   <= cnt_d;
      out_ovf_q   <= ovf_d;
      out_negz_q  <= (acc_d == ALL_ONES);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;
  assign out_negz  = out_negz_q;

endmodule

// File: tb/tb_c1_accum_w.sv
// Bench for c1_accum_w: three instances share one handshake, checked each cycle
// against a value-level C1 model plus hand-computed literal expectations.
module tb_c1_accum_w;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;

  logic        a_in_ready, a_out_valid, a_out_ovf, a_out_negz;
  logic [15:0] a_out_sum;
  logic [7:0]  a_out_cnt;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_out_negz;
  logic [15:0] b_out_sum;
  logic [7:0]  b_out_cnt;
  logic        c_in_ready, c_out_valid, c_out_ovf, c_out_negz;
  logic [3:0]  c_out_sum;
  logic [1:0]  c_out_cnt;

  always #5 clk = ~clk;

  c1_accum_w #(.W(16), .CNT_W(8), .OUT_INV(1'b0)) dut_a (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_cnt(a_out_cnt), .out_ovf(a_out_ovf), .out_negz(a_out_negz));

  c1_accum_w #(.W(16), .CNT_W(8), .OUT_INV(1'b1)) dut_b (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_cnt(b_out_cnt), .out_ovf(b_out_ovf), .out_negz(b_out_negz));

  c1_accum_w #(.W(4), .CNT_W(2), .OUT_INV(1'b0)) dut_c (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data[3:0]), .in_sub(in_sub), .in_last(in_last),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_sum(c_out_sum),
    .out_cnt(c_out_cnt), .out_ovf(c_out_ovf), .out_negz(c_out_negz));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value-level model: index 0 is the 16-bit/8-bit-count view, index 1 the 4-bit/2-bit view.
  int MW[2]   = '{16, 4};
  int CMAX[2] = '{255, 3};
  int m_acc[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  bit m_ovf[2] = '{0, 0};
  bit m_hold   = 1'b0;

  function automatic int c1_val(input int x, input int w);
    if (((x >> (w - 1)) & 1) != 0) return -(((1 << w) - 1) ^ x);
    return x;
  endfunction

  // Sum modulo 2^w-1, keeping the representation the end-around carry yields.
  function automatic int c1_add(input int a, input int b, input int w);
    int s;
    s = a + b;
    if (s >= (1 << w)) s = s - (1 << w) + 1;
    return s;
  endfunction

  always @(posedge clk or negedge rst_b) begin : model
    int mask, d, op, t, lim;
    if (!rst_b) begin
      m_hold = 1'b0;
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0; end
    end else if (!m_hold) begin
      if (in_valid) begin
        for (int k = 0; k < 2; k++) begin
          mask = (1 << MW[k]) - 1;
          lim  = (1 << (MW[k] - 1)) - 1;
          d    = int'(in_data) & mask;
          op   = in_sub ? (d ^ mask) : d;
          t    = c1_val(m_acc[k], MW[k]) + c1_val(op, MW[k]);
          if (t > lim || t < -lim) m_ovf[k] = 1'b1;
          m_acc[k] = c1_add(m_acc[k], op, MW[k]);
          if (m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
        end
        if (in_last) m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0; end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    check("a_in_ready", a_in_ready, !m_hold);
    check("a_out_valid", a_out_valid, m_hold);
    check("a_out_sum", a_out_sum, m_acc[0]);
    check("a_out_cnt", a_out_cnt, m_cnt[0]);
    check("a_out_ovf", a_out_ovf, m_ovf[0]);
    check("a_out_negz", a_out_negz, m_acc[0] == 16'hFFFF);
    check("b_in_ready", b_in_ready, !m_hold);
    check("b_out_valid", b_out_valid, m_hold);
    check("b_out_sum", b_out_sum, m_acc[0] ^ 32'hFFFF);
    check("b_out_cnt", b_out_cnt, m_cnt[0]);
    check("b_out_ovf", b_out_ovf, m_ovf[0]);
    check("b_out_negz", b_out_negz, m_acc[0] == 16'hFFFF);
    check("c_in_ready", c_in_ready, !m_hold);
    check("c_out_valid", c_out_valid, m_hold);
    check("c_out_sum", c_out_sum, m_acc[1]);
    check("c_out_cnt", c_out_cnt, m_cnt[1]);
    check("c_out_ovf", c_out_ovf, m_ovf[1]);
    check("c_out_negz", c_out_negz, m_acc[1] == 15);
  end

  logic [15:0] qd[$];
  bit          qs[$];

  task automatic push(input logic [15:0] d, input bit s);
    qd.push_back(d);
    qs.push_back(s);
  endtask

  // Called at a negedge while accepting; leaves off at the negedge after the last accept.
  task automatic send_pkt(input int gapmax, input bit no_last);
    int g;
    for (int i = 0; i < qd.size(); i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0; in_data = 16'($urandom); in_sub = 1'($urandom); in_last = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = qd[i]; in_sub = qs[i];
      in_last  = !no_last && (i == qd.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!no_last) check("latency_out_valid", a_out_valid, 1'b1);
    qd.delete();
    qs.delete();
  endtask

  // Hold the result for a while with in_valid noise, then take it.
  task automatic consume(input int stall);
    int n;
    n = 0;
    while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
    check("wait_out_valid", a_out_valid, 1'b1);
    repeat (stall) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom); in_data = 16'($urandom); in_sub = 1'($urandom); in_last = 1'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r;
    int len;
    repeat (2) @(negedge clk);
    check("reset_in_ready", a_in_ready, 1'b1);
    check("reset_b_sum", b_out_sum, 16'hFFFF);
    rst_b = 1'b1;
    @(negedge clk);

    push(16'hFFFF, 0); push(16'h0001, 0); send_pkt(0, 0);
    check("t1_sum", a_out_sum, 16'h0001);
    check("t1_cnt", a_out_cnt, 2);
    check("t1_ovf", a_out_ovf, 0);
    check("t1_negz", a_out_negz, 0);
    consume(0);

    push(16'h8000, 0); push(16'h8000, 0); send_pkt(0, 0);
    check("t2_sum", a_out_sum, 16'h0001);
    check("t2_ovf", a_out_ovf, 1);
    consume(1);

    push(16'h1234, 0); push(16'hEDCB, 0); send_pkt(0, 0);
    check("t3_sum", a_out_sum, 16'hFFFF);
    check("t3_negz", a_out_negz, 1);
    check("t3_inv_sum", b_out_sum, 16'h0000);
    consume(0);

    push(16'h0005, 0); push(16'h0003, 1); send_pkt(0, 0);
    check("t4_sum", a_out_sum, 16'h0002);
    repeat (5) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b1;
      @(negedge clk);
    end
    check("t4_stable_sum", a_out_sum, 16'h0002);
    check("t4_stable_ready", a_in_ready, 0);
    check("t4_stable_valid", a_out_valid, 1);
    consume(0);
    push(16'h0007, 0); send_pkt(0, 0);
    check("t4_next_sum", a_out_sum, 16'h0007);
    check("t4_next_cnt", a_out_cnt, 1);
    consume(2);

    push(16'h1000, 0); push(16'h2000, 0); send_pkt(0, 1);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("t5_in_ready", a_in_ready, 1);
    check("t5_out_valid", a_out_valid, 0);
    check("t5_sum", a_out_sum, 16'h0000);
    check("t5_cnt", a_out_cnt, 0);
    check("t5_inv_sum", b_out_sum, 16'hFFFF);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    push(16'h0003, 0); send_pkt(0, 0);
    check("t5_after_sum", a_out_sum, 16'h0003);
    check("t5_after_cnt", a_out_cnt, 1);
    consume(0);

    repeat (5) push(16'h0001, 0);
    send_pkt(0, 0);
    check("t6_cnt_sat", c_out_cnt, 3);
    check("t6_sum4", c_out_sum, 4'h5);
    check("t6_cnt16", a_out_cnt, 5);
    consume(0);

    push(16'h0007, 0); push(16'h0001, 0); send_pkt(0, 0);
    check("w4_ovf_sum", c_out_sum, 4'h8);
    check("w4_ovf", c_out_ovf, 1);
    check("w16_no_ovf", a_out_ovf, 0);
    consume(0);

    // All 4-bit operand pairs in add and subtract mode, with random upper bits.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++) begin
          r = $urandom; push({r[15:4], 4'(a)}, 0);
          r = $urandom; push({r[15:4], 4'(b)}, 1'(s));
          send_pkt(0, 0);
          consume(0);
        end

    for (int p = 0; p < 300; p++) begin
      len = int'($urandom_range(6, 1));
      for (int i = 0; i < len; i++) push(16'($urandom), 1'($urandom));
      send_pkt(2, 0);
      consume(int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
